// File: rtl/push_switch_conditioner.sv
// push_switch_conditioner
//   Conditions N_SW raw push switches. Each channel is fully independent:
//   two-flop synchronizer, debounce counter, and a small hold/auto-repeat FSM.
//   All outputs come straight from flops.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-low reset
//   push_switch : raw asynchronous switches, 1 = pressed
//   sw_level    : debounced level
//   sw_press    : one-cycle pulse when a press is accepted
//   sw_release  : one-cycle pulse when a release is accepted
//   sw_repeat   : auto-repeat pulse while held (first after HOLD, then every REPEAT)
//
// Channel FSM
//   state     | meaning
//   IDLE      | level 0
//   HOLDING   | level 1, counting towards the first repeat
//   REPEATING | level 1, repeat pulse every REPEAT cycles
module push_switch_conditioner #(
  parameter int N_SW     = 6,
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 10,
  parameter int REPEAT   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] push_switch,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_press,
  output logic [N_SW-1:0] sw_release,
  output logic [N_SW-1:0] sw_repeat
);

  localparam int DW   = $clog2(DEBOUNCE) + 1;
  localparam int HMAX = (HOLD > REPEAT) ? HOLD : REPEAT;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0] HOLD_C   = HW'(HOLD);
  localparam logic [HW-1:0] REPEAT_C = HW'(REPEAT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLDING   = 2'd1,
    REPEATING = 2'd2
  } state_t;

  for (genvar g = 0; g < N_SW; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic [DW-1:0] r_db_cnt;
    logic [DW-1:0] w_db_cnt_next;
    logic          w_accept;
    logic          r_level;
    state_t        r_state;
    state_t        w_state_next;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_next;
    logic [HW-1:0] w_hold_inc;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    logic          w_press_next;
    logic          w_release_next;
    logic          w_repeat_next;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= push_switch[g];
        r_sync2 <= r_sync1;
      end
    end

    // Any cycle where the synced input agrees with the level restarts the
    // count, so only DEBOUNCE consecutive disagreeing cycles are accepted.
    always_comb begin
      w_accept      = 1'b0;
      w_db_cnt_next = '0;
      if (r_sync2 != r_level) begin
        if (r_db_cnt == DB_LAST) begin
          w_accept = 1'b1;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_db_cnt <= '0;
        r_level  <= 1'b0;
      end else begin
        r_db_cnt <= w_db_cnt_next;
        if (w_accept) begin
          r_level <= r_sync2;
        end
      end
    end

    // Counter holds cycles since press (or since last repeat); it is cleared
    // when a repeat fires, so it never needs to exceed max(HOLD, REPEAT).
    always_comb begin
      w_state_next   = r_state;
      w_hold_next    = r_hold_cnt;
      w_hold_inc     = r_hold_cnt + 1'b1;
      w_press_next   = 1'b0;
      w_release_next = 1'b0;
      w_repeat_next  = 1'b0;
      case (r_state)
        IDLE: begin
          w_hold_next = '0;
          if (w_accept && r_sync2) begin
            w_state_next = HOLDING;
            w_hold_next  = HW'(1);
            w_press_next = 1'b1;
          end
        end
        HOLDING: begin
          if (w_accept) begin
            w_state_next   = IDLE;
            w_hold_next    = '0;
            w_release_next = 1'b1;
          end else if (w_hold_inc == HOLD_C) begin
            w_state_next  = REPEATING;
            w_hold_next   = '0;
            w_repeat_next = 1'b1;
          end else begin
            w_hold_next = w_hold_inc;
          end
        end
        REPEATING: begin
          if (w_accept) begin
            w_state_next   = IDLE;
            w_hold_next    = '0;
            w_release_next = 1'b1;
          end else if (w_hold_inc == REPEAT_C) begin
            w_hold_next   = '0;
            w_repeat_next = 1'b1;
          end else begin
            w_hold_next = w_hold_inc;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_hold_next  = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_state    <= IDLE;
        r_hold_cnt <= '0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_state    <= w_state_next;
        r_hold_cnt <= w_hold_next;
        r_press    <= w_press_next;
        r_release  <= w_release_next;
        r_repeat   <= w_repeat_next;
      end
    end

    assign sw_level[g]   = r_level;
    assign sw_press[g]   = r_press;
    assign sw_release[g] = r_release;
    assign sw_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_push_switch_conditioner.sv
// Bench for push_switch_conditioner (DEBOUNCE=4, HOLD=10, REPEAT=3, N_SW=6).
// Cycle n is the interval after posedge n; table row n is driven #1 after
// posedge n and its expected outputs are compared at the negedge of cycle n.
module tb_push_switch_conditioner;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] push_switch = '0;
  logic [N-1:0] sw_level;
  logic [N-1:0] sw_press;
  logic [N-1:0] sw_release;
  logic [N-1:0] sw_repeat;

  always #5 clk = ~clk;

  push_switch_conditioner #(
    .N_SW(N), .DEBOUNCE(4), .HOLD(10), .REPEAT(3)
  ) dut (
    .clk(clk), .reset(reset), .push_switch(push_switch),
    .sw_level(sw_level), .sw_press(sw_press),
    .sw_release(sw_release), .sw_repeat(sw_repeat)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] sw;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } vec_t;

  vec_t tbl [0:63];
  vec_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic running = 1'b0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // repeat must never coincide with press or release on any channel
  always @(negedge clk) begin
    if (running) begin
      check("repeat_overlap", sw_repeat & (sw_press | sw_release), '0);
    end
  end

  task automatic clear_tbl();
    for (int i = 0; i < 64; i++) begin
      tbl[i].rst = 1'b1;
      tbl[i].sw  = '0;
      tbl[i].lvl = '0;
      tbl[i].prs = '0;
      tbl[i].rel = '0;
      tbl[i].rpt = '0;
    end
  endtask

  task automatic sw_on(input int ch, input int a, input int b);
    for (int i = a; i <= b; i++) tbl[i].sw[ch] = 1'b1;
  endtask

  task automatic lvl_on(input int ch, input int a, input int b);
    for (int i = a; i <= b; i++) tbl[i].lvl[ch] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    push_switch = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset level",   sw_level,   '0);
    check("reset press",   sw_press,   '0);
    check("reset release", sw_release, '0);
    check("reset repeat",  sw_repeat,  '0);
  endtask

  task automatic run_table(input string name, input int len);
    vec_t e;
    do_reset();
    for (int i = 0; i < len; i++) begin
      reset = tbl[i].rst;
      push_switch = tbl[i].sw;
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL %s c%0d: scoreboard empty", name, i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s c%0d level", name, i),   sw_level,   e.lvl);
        check($sformatf("%s c%0d press", name, i),   sw_press,   e.prs);
        check($sformatf("%s c%0d release", name, i), sw_release, e.rel);
        check($sformatf("%s c%0d repeat", name, i),  sw_repeat,  e.rpt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    running = 1'b1;

    // clean press on ch0, held, then released
    clear_tbl();
    sw_on(0, 0, 29);
    lvl_on(0, 6, 35);
    tbl[6].prs[0] = 1'b1;
    for (int c = 15; c <= 33; c += 3) tbl[c].rpt[0] = 1'b1;
    tbl[36].rel[0] = 1'b1;
    run_table("hold_repeat", 42);

    // bouncing ch1: 1,0,1,1,0,1 then steady 1
    clear_tbl();
    sw_on(1, 0, 0);
    sw_on(1, 2, 3);
    sw_on(1, 5, 21);
    lvl_on(1, 11, 21);
    tbl[11].prs[1] = 1'b1;
    tbl[20].rpt[1] = 1'b1;
    run_table("bounce", 22);

    // ch2 and ch5 pressed together, ch2 released three cycles earlier
    clear_tbl();
    sw_on(2, 0, 9);
    sw_on(5, 0, 12);
    lvl_on(2, 6, 15);
    lvl_on(5, 6, 18);
    tbl[6].prs[2] = 1'b1;
    tbl[6].prs[5] = 1'b1;
    tbl[15].rpt[2] = 1'b1;
    tbl[15].rpt[5] = 1'b1;
    tbl[18].rpt[5] = 1'b1;
    tbl[16].rel[2] = 1'b1;
    tbl[19].rel[5] = 1'b1;
    run_table("two_ch", 22);

    // one-cycle reset at cycle 12 while ch0 held
    clear_tbl();
    sw_on(0, 0, 29);
    tbl[12].rst = 1'b0;
    lvl_on(0, 6, 12);
    lvl_on(0, 19, 29);
    tbl[6].prs[0]  = 1'b1;
    tbl[19].prs[0] = 1'b1;
    tbl[28].rpt[0] = 1'b1;
    run_table("mid_reset", 30);

    // 3-cycle pulse on ch3 rejected, 4-cycle pulse on ch4 accepted
    clear_tbl();
    sw_on(3, 2, 4);
    sw_on(4, 2, 5);
    lvl_on(4, 8, 11);
    tbl[8].prs[4]  = 1'b1;
    tbl[12].rel[4] = 1'b1;
    run_table("glitch", 16);

    // reset coinciding with the press edge wins; press re-accepted later
    do_reset();
    reset = 1'b1;
    push_switch = 6'b000001;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_prio c6 press", sw_press, '0);
    check("rst_prio c6 level", sw_level, '0);
    reset = 1'b1;
    for (int c = 7; c <= 12; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_prio c%0d press", c), sw_press, (c == 12) ? 6'b000001 : 6'b000000);
    end

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
